// File: rtl/axi_lite_burst_reader.sv
// axi_lite_burst_reader: reads a block of BLOCK_WORDS words over AXI4-Lite
// as back-to-back single-beat reads. Beat k is read from base + k*INCR_VAL,
// and its data is placed in word k of o_block. One read is in flight at a time.
module axi_lite_burst_reader #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int BLOCK_WORDS    = 16,
   parameter int INCR_VAL       = 4
) (
   input  logic                                  i_clk,
   input  logic                                  i_arst,
   input  logic                                  i_start,
   input  logic [AXI_ADDR_WIDTH-1:0]             i_base_addr,
   output logic                                  o_busy,
   output logic                                  o_done,
   output logic                                  o_error,
   output logic [BLOCK_WORDS*AXI_DATA_WIDTH-1:0] o_block,
   output logic [AXI_ADDR_WIDTH-1:0]             o_araddr,
   output logic                                  o_arvalid,
   input  logic                                  i_arready,
   input  logic [AXI_DATA_WIDTH-1:0]             i_rdata,
   input  logic [1:0]                            i_rresp,
   input  logic                                  i_rvalid,
   output logic                                  o_rready
);

   localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] INCR = AXI_ADDR_WIDTH'(INCR_VAL);
   localparam int BLK_W = BLOCK_WORDS * AXI_DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          beat_q, beat_d;
   logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                      err_q, err_d;
   logic [BLK_W-1:0]          block_q, block_d;
   logic                      arvalid_q, arvalid_d;
   logic                      rready_q, rready_d;
   logic                      done_q, done_d;
   logic                      error_q, error_d;
   logic                      busy_q, busy_d;
   logic                      word_wr;

   // Next-state, beat address, block update, and registered outputs
   // derived from the next state so every output is a flop.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      base_d   = base_q;
      araddr_d = araddr_q;
      err_d    = err_q;
      block_d  = block_q;
      word_wr  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               base_d   = i_base_addr;
               beat_d   = '0;
               err_d    = 1'b0;
               araddr_d = i_base_addr;
               state_d  = S_ADDR;
            end
         end
         S_ADDR: begin
            // araddr_q is only updated outside ADDR, so it is stable during a stall
            if (i_arready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (i_rvalid) begin
               word_wr = 1'b1;
               if (i_rresp != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (beat_q == LAST_BEAT) begin
                  state_d = S_DONE;
               end else begin
                  beat_d   = beat_q + 1'b1;
                  // Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH
                  araddr_d = base_q + AXI_ADDR_WIDTH'(beat_d) * INCR;
                  state_d  = S_ADDR;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Only the word for the current beat is rewritten; others keep old data
      for (int w = 0; w < BLOCK_WORDS; w++) begin
         if (word_wr && (beat_q == CNT_W'(w))) begin
            block_d[w*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
         end
      end

      arvalid_d = (state_d == S_ADDR);
      rready_d  = (state_d == S_DATA);
      done_d    = (state_d == S_DONE);
      error_d   = (state_d == S_DONE) && err_d;
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts silently with no done pulse.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         base_q    <= '0;
         araddr_q  <= '0;
         err_q     <= 1'b0;
         block_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         araddr_q  <= araddr_d;
         err_q     <= err_d;
         block_q   <= block_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         done_q    <= done_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
      end
   end

   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_error   = error_q;
   assign o_block   = block_q;
   assign o_araddr  = araddr_q;
   assign o_arvalid = arvalid_q;
   assign o_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_burst_reader.sv
// Directed bench for axi_lite_burst_reader: the bench plays the AXI slave in
// lockstep with the DUT, driving and sampling on the falling clock edge.
module tb_axi_lite_burst_reader;

   localparam int AW = 64;
   localparam int DW = 32;
   localparam int BW = 16;

   logic              clk = 1'b0;
   logic              arst;
   logic              start;
   logic [AW-1:0]     base_addr;
   logic              busy, done, error;
   logic [BW*DW-1:0]  block;
   logic [AW-1:0]     araddr;
   logic              arvalid;
   logic              arready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   int ar_stall [BW];
   int r_delay  [BW];
   logic [BW*DW-1:0] exp_block;

   axi_lite_burst_reader #(
      .AXI_ADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(DW),
      .BLOCK_WORDS(BW),
      .INCR_VAL(4)
   ) dut (
      .i_clk(clk),
      .i_arst(arst),
      .i_start(start),
      .i_base_addr(base_addr),
      .o_busy(busy),
      .o_done(done),
      .o_error(error),
      .o_block(block),
      .o_araddr(araddr),
      .o_arvalid(arvalid),
      .i_arready(arready),
      .i_rdata(rdata),
      .i_rresp(rresp),
      .i_rvalid(rvalid),
      .o_rready(rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_stalls();
      for (int i = 0; i < BW; i++) begin
         ar_stall[i] = 0;
         r_delay[i]  = 0;
      end
   endtask

   // Runs one block as the slave. err_beat / rst_beat < 0 disable those events.
   task automatic run_block(input logic [AW-1:0] base, input logic [DW-1:0] dbase,
                            input int err_beat, input int rst_beat, input bit skip_start,
                            input bit hold_start, input bit chk_lat, input logic [AW-1:0] mid_base);
      logic [AW-1:0] exp_addr;
      bit aborted;
      bit err;
      bit was_reset;
      aborted   = 1'b0;
      err       = 1'b0;
      was_reset = 1'b0;
      if (!skip_start) begin
         start     = 1'b1;
         base_addr = base;
         cyc       = 0;
         tick();
         if (!hold_start) start = 1'b0;
      end
      for (int k = 0; k < BW && !aborted; k++) begin
         exp_addr = base + AW'(k) * 64'd4;
         if (k == 2) base_addr = mid_base;
         checks++;
         if (arvalid !== 1'b1 || araddr !== exp_addr) begin
            $display("FAIL ar_issue beat %0d: arvalid=%b araddr=%h, expected arvalid=1 araddr=%h",
                     k, arvalid, araddr, exp_addr);
         end else passes++;
         for (int s = 0; s < ar_stall[k]; s++) begin
            arready = 1'b0;
            tick();
            checks++;
            if (arvalid !== 1'b1 || araddr !== exp_addr) begin
               $display("FAIL ar_stall beat %0d: arvalid=%b araddr=%h, expected arvalid=1 araddr=%h",
                        k, arvalid, araddr, exp_addr);
            end else passes++;
         end
         arready = 1'b1;
         tick();
         arready = 1'b0;
         checks++;
         if (rready !== 1'b1 || arvalid !== 1'b0) begin
            $display("FAIL data_phase beat %0d: rready=%b arvalid=%b, expected rready=1 arvalid=0",
                     k, rready, arvalid);
         end else passes++;
         for (int d = 0; d < r_delay[k]; d++) begin
            tick();
            checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0) begin
               $display("FAIL r_wait beat %0d: rready=%b arvalid=%b, expected rready=1 arvalid=0",
                        k, rready, arvalid);
            end else passes++;
         end
         if (k == rst_beat) begin
            arst = 1'b1;
            tick();
            arst = 1'b0;
            checks++;
            if (busy !== 1'b0 || rready !== 1'b0 || block !== '0 || done !== 1'b0) begin
               $display("FAIL mid_reset: busy=%b rready=%b done=%b block_nonzero=%b, expected all 0",
                        busy, rready, done, (block != '0));
            end else passes++;
            aborted   = 1'b1;
            was_reset = 1'b1;
         end else begin
            rvalid = 1'b1;
            rdata  = dbase + DW'(k);
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            exp_block[k*DW +: DW] = rdata;
            tick();
            rvalid = 1'b0;
            rresp  = 2'b00;
            if (k == err_beat) begin
               err     = 1'b1;
               aborted = 1'b1;
            end
         end
      end
      if (was_reset) begin
         exp_block = '0;
         for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
               $display("FAIL post_reset_quiet: done=%b busy=%b, expected 0 0", done, busy);
            end else passes++;
         end
         $display("block base=%h aborted by reset", base);
      end else begin
         checks++;
         if (done !== 1'b1 || error !== err) begin
            $display("FAIL done_pulse: done=%b error=%b, expected done=1 error=%b", done, error, err);
         end else passes++;
         if (chk_lat) begin
            checks++;
            if (cyc != 2 * BW + 1) begin
               $display("FAIL done_latency: cycle=%0d, expected %0d", cyc, 2 * BW + 1);
            end else passes++;
         end
         checks++;
         if (block !== exp_block) begin
            $display("FAIL block_data: got %h, expected %h", block, exp_block);
         end else passes++;
         $display("block base=%h done error=%b word0=%h", base, error, block[DW-1:0]);
         tick();
         checks++;
         if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) begin
            $display("FAIL after_done: done=%b error=%b busy=%b arvalid=%b, expected all 0",
                     done, error, busy, arvalid);
         end else passes++;
      end
   endtask

   task automatic test_reset();
      arst = 1'b1; start = 1'b0; base_addr = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      exp_block = '0;
      clear_stalls();
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || done !== 1'b0 ||
          error !== 1'b0 || block !== '0) begin
         $display("FAIL reset_state: busy=%b arvalid=%b rready=%b done=%b error=%b, expected all 0",
                  busy, arvalid, rready, done, error);
      end else passes++;
      // start coinciding with reset must lose to reset
      start = 1'b1; base_addr = 64'h1000;
      tick();
      arst = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0 || arvalid !== 1'b0) begin
         $display("FAIL start_vs_reset: busy=%b arvalid=%b, expected 0 0", busy, arvalid);
      end else passes++;
      tick();
      checks++;
      if (busy !== 1'b0 || arvalid !== 1'b0) begin
         $display("FAIL idle_hold: busy=%b arvalid=%b, expected 0 0", busy, arvalid);
      end else passes++;
   endtask

   task automatic test_zero_wait();
      clear_stalls();
      run_block(64'h1000, 32'hA000_0000, -1, -1, 1'b0, 1'b0, 1'b1, 64'h1000);
      checks++;
      if (block[5*DW +: DW] !== 32'hA000_0005) begin
         $display("FAIL word5: got %h, expected a0000005", block[5*DW +: DW]);
      end else passes++;
   endtask

   task automatic test_backpressure();
      clear_stalls();
      ar_stall[2] = 3;
      r_delay[7]  = 4;
      run_block(64'h1000, 32'hA000_0000, -1, -1, 1'b0, 1'b0, 1'b0, 64'h1000);
   endtask

   task automatic test_error();
      clear_stalls();
      run_block(64'h1000, 32'hC000_0000, 3, -1, 1'b0, 1'b0, 1'b0, 64'h1000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (arvalid !== 1'b0) begin
            $display("FAIL no_ar_after_error: arvalid=%b, expected 0", arvalid);
         end else passes++;
      end
      checks++;
      if (block[15*DW +: DW] !== 32'hA000_000F) begin
         $display("FAIL word15_kept: got %h, expected a000000f", block[15*DW +: DW]);
      end else passes++;
   endtask

   task automatic test_wrap();
      clear_stalls();
      run_block(64'hFFFF_FFFF_FFFF_FFF8, 32'hD000_0000, -1, -1, 1'b0, 1'b0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFF8);
   endtask

   task automatic test_reset_mid();
      clear_stalls();
      run_block(64'h3000, 32'h5000_0000, -1, 5, 1'b0, 1'b0, 1'b0, 64'h3000);
      run_block(64'h4000, 32'h6000_0000, -1, -1, 1'b0, 1'b0, 1'b1, 64'h4000);
   endtask

   task automatic test_back_to_back();
      clear_stalls();
      run_block(64'h2000, 32'hE000_0000, -1, -1, 1'b0, 1'b1, 1'b0, 64'h9000);
      tick();
      start = 1'b0;
      run_block(64'h9000, 32'hF000_0000, -1, -1, 1'b1, 1'b0, 1'b0, 64'h9000);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_error();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_burst_reader.md
Name: axi_lite_burst_reader

Overview:
- Sequences a multi-word block read over AXI4-Lite as back-to-back single-beat transactions.
- Generates the per-beat address as base + 4*k, drives the AR and R channels, and assembles the returned 32-bit words into one block register.
- Sits on the memory side of the cache / fetch path: it consumes a block-read request, produces a filled block, and raises a done/error pulse.

Parameters:
AXI_ADDR_WIDTH, 64, address width of request base and AR channel.
AXI_DATA_WIDTH, 32, R channel data width; also the word size.
BLOCK_WORDS, 16, words per block; must be >= 1.
INCR_VAL, 4, byte increment between consecutive beat addresses.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_arst  in  1  reset; synchronous, active-high.
i_start  in  1  block-read request; sampled only in IDLE.
i_base_addr  in  AXI_ADDR_WIDTH  block base address; captured when i_start is accepted.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle pulse when the block completes or aborts.
o_error  out  1  valid with o_done; 1 means aborted on a non-OKAY response.
o_block  out  BLOCK_WORDS*AXI_DATA_WIDTH  assembled block; word k at bits [32k+31:32k].
o_araddr  out  AXI_ADDR_WIDTH  AR address.
o_arvalid  out  1  AR valid.
i_arready  in  1  AR ready.
i_rdata  in  AXI_DATA_WIDTH  R data.
i_rresp  in  2  R response.
i_rvalid  in  1  R valid.
o_rready  out  1  R ready.

Behaviour:
- Reset (i_arst=1 at a clock edge):
  - State goes to IDLE; beat counter = 0; captured base = 0.
  - o_arvalid, o_rready, o_done, o_error, o_busy = 0; o_block = 0.
  - Reset mid-transfer aborts with no o_done pulse. Any outstanding AXI response after reset is ignored because o_rready=0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On i_start=1, capture i_base_addr, clear the beat counter k and the error flag, and go to ADDR.
  - i_start is ignored in all other states.
- ADDR:
  - o_arvalid=1, o_araddr = base + k*INCR_VAL, computed modulo 2^AXI_ADDR_WIDTH (wrap silently, no error).
  - o_araddr stays stable while o_arvalid=1 and i_arready=0.
  - On i_arready=1, go to DATA.
- DATA:
  - o_rready=1, o_arvalid=0; at most one transaction outstanding.
  - On i_rvalid=1, write i_rdata into word k of o_block, then:
    - If i_rresp != 2'b00: set the error flag and go to DONE. Remaining words keep their prior contents.
    - Else if k == BLOCK_WORDS-1: go to DONE.
    - Else: k <= k+1 and go to ADDR.
- DONE:
  - o_done=1 for exactly one cycle; o_error = error flag; then go to IDLE.
  - o_error is 0 whenever o_done is 0.
- o_block holds its value after DONE until a later DATA-state write. Words not rewritten by the next block keep their old values.
- Latency, zero-wait slave (arready=1, rvalid one cycle after the AR handshake):
  - i_start accepted at cycle 0; o_arvalid=1 at cycle 1.
  - Each beat takes 2 cycles (ADDR + DATA).
  - o_done is asserted at cycle 2*BLOCK_WORDS+1.
- A simultaneous i_start and i_arst resolves to reset.
- AXI rule compliance: o_arvalid is never dropped before its handshake. o_rready is high only in DATA.

Test Plan:
- Zero-wait slave, BLOCK_WORDS=16, base=0x1000, R returns word k = 0xA0000000+k:
  - araddr sequence is 0x1000, 0x1004, …, 0x103C.
  - o_done at cycle 33; o_error=0.
  - o_block word 5 = 0xA0000005.
- Backpressure: i_arready low for 3 cycles on beat 2, i_rvalid delayed 4 cycles on beat 7:
  - o_araddr=0x1008 and o_arvalid stay stable during the stall.
  - o_rready stays high while waiting.
  - Final block is identical to the zero-wait case.
- Error abort: i_rresp=2'b10 on beat 3:
  - o_done pulses with o_error=1 after that beat.
  - No further AR issued; words 4..15 unchanged from their prior values.
- Wrap-around: base=0xFFFF_FFFF_FFFF_FFF8, BLOCK_WORDS=4:
  - araddr sequence is …FFF8, …FFFC, 0x0, 0x4.
  - Completes with o_error=0.
- Reset mid-operation: assert i_arst while in DATA on beat 5:
  - Next cycle o_busy=0, o_rready=0, o_block=0; no o_done pulse.
  - A new i_start then runs normally from beat 0.
- i_start held high continuously:
  - Second block starts only from IDLE, one cycle after the DONE pulse.
  - i_base_addr changes during a transfer have no effect.
